// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing controller: load-use stalls, branch flushes, mul/div EX occupancy, dmem waits.
// Optional perf counters (stall_cycles, flush_events) built when HAZARD_PERF_CNT_EN is defined.
module hazard_stall_controller #(
  parameter int unsigned MULDIV_LAT = 4,
  parameter int unsigned PERF_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_rd_ex,
  input  logic [4:0]        rd_ex,
  input  logic [4:0]        rs1_de,
  input  logic [4:0]        rs2_de,
  input  logic              use_rs1_de,
  input  logic              use_rs2_de,
  input  logic              branch_taken_ex,
  input  logic              muldiv_ex,
  input  logic              dm_busy,
  output logic              en_pc,
  output logic              en_de,
  output logic              en_ex,
  output logic              en_me,
  output logic              en_wb,
  output logic              flush_de,
  output logic              flush_ex,
  output logic              flush_me,
  output logic              md_done,
  output logic [1:0]        fsm_state,
  output logic [PERF_W-1:0] stall_cycles,
  output logic [PERF_W-1:0] flush_events
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    MD_BUSY = 2'b01,
    MD_DONE = 2'b10
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   md_cnt_q, md_cnt_d;
  logic               load_use_c;

  assign load_use_c = mem_rd_ex && (rd_ex != 5'd0) &&
                      ((use_rs1_de && (rs1_de == rd_ex)) ||
                       (use_rs2_de && (rs2_de == rd_ex)));

  assign fsm_state = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      md_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  // Next state and pipeline controls; dm_busy freezes everything except the mul/div countdown.
  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    en_pc    = 1'b1;
    en_de    = 1'b1;
    en_ex    = 1'b1;
    en_me    = 1'b1;
    en_wb    = 1'b1;
    flush_de = 1'b0;
    flush_ex = 1'b0;
    flush_me = 1'b0;
    md_done  = 1'b0;

    if (rst) begin
      en_pc = 1'b0;
      en_de = 1'b0;
      en_ex = 1'b0;
      en_me = 1'b0;
      en_wb = 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (dm_busy) begin
            en_pc = 1'b0;
            en_de = 1'b0;
            en_ex = 1'b0;
            en_me = 1'b0;
            en_wb = 1'b0;
          end else if (muldiv_ex) begin
            en_pc    = 1'b0;
            en_de    = 1'b0;
            en_ex    = 1'b0;
            en_me    = 1'b0;
            flush_me = 1'b1;
            state_d  = MD_BUSY;
            md_cnt_d = CNT_W'(MULDIV_LAT - 2);
          end else if (branch_taken_ex) begin
            flush_de = 1'b1;
            flush_ex = 1'b1;
          end else if (load_use_c) begin
            en_pc    = 1'b0;
            en_de    = 1'b0;
            flush_ex = 1'b1;
          end
        end

        MD_BUSY: begin
          // The unit keeps running even while memory stalls the pipe; park at zero.
          if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - CNT_W'(1);
          end
          if (dm_busy) begin
            en_pc = 1'b0;
            en_de = 1'b0;
            en_ex = 1'b0;
            en_me = 1'b0;
            en_wb = 1'b0;
          end else begin
            en_pc    = 1'b0;
            en_de    = 1'b0;
            en_ex    = 1'b0;
            en_me    = 1'b0;
            flush_me = 1'b1;
            if (md_cnt_q == '0) begin
              state_d = MD_DONE;
            end
          end
        end

        MD_DONE: begin
          md_done = 1'b1;
          if (dm_busy) begin
            en_pc = 1'b0;
            en_de = 1'b0;
            en_ex = 1'b0;
            en_me = 1'b0;
            en_wb = 1'b0;
          end else begin
            state_d = RUN;
          end
        end

        default: begin
          state_d  = RUN;
          md_cnt_d = '0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [PERF_W-1:0] flush_events_q, flush_events_d;

  // Saturating event counters.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_events_d = flush_events_q;
    if (!en_pc && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + PERF_W'(1);
    end
    if ((flush_de || flush_ex) && (flush_events_q != '1)) begin
      flush_events_d = flush_events_q + PERF_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule
